btn_press_counter: RTL and testbench
====================================

// Module: btn_press_counter
// PURPOSE
//   Input-side companion to the LED counter block: reads one raw push-button,
//   synchronises and debounces it, and emits press/release/long-press events.
//   Keeps an 8-bit press count that can drive the board LED bank directly.
//   Sits between the board BTN pin and top-level LED/control logic.
// PARAMETERS
//   DEBOUNCE    10   cycles BTN must be stable to accept an edge (>=1)
//   LONG_PRESS  100  cycles after an accepted press at which LONG fires (>=1)
// PORTS
//   CLK      in   1  system clock, all logic on posedge
//   RST      in   1  reset, asynchronous assert, active-low (0 = reset)
//   BTN      in   1  raw, asynchronous, bouncing button (1 = pressed)
//   PRESS    out  1  one-cycle pulse: debounced press accepted
//   RELEASE  out  1  one-cycle pulse: debounced release accepted
//   LONG     out  1  one-cycle pulse: press held LONG_PRESS cycles
//   HELD     out  1  level: debounced button state
//   COUNT    out  8  number of accepted presses, modulo 256
// BEHAVIOUR
//   Reset (RST=0): all outputs 0, FSM=IDLE, sync flops 0, counters 0.
//   Reset is asynchronous. A reset in mid-press discards the press; no pulses.
//   Sync: 2-flop synchroniser on BTN gives s2. The FSM only ever sees s2.
//   Debounce counter dcnt [31:0]. Hold counter hcnt [31:0], saturates at max.
//   FSM (all outputs registered; pulses are default-0 each cycle):
//   - IDLE: s2=1 -> PRESS_WAIT, dcnt=0.
//   - PRESS_WAIT: s2=0 -> IDLE (glitch rejected, no outputs).
//     Else if dcnt==DEBOUNCE-1 -> PRESSED: PRESS=1, HELD=1, COUNT+=1, hcnt=0.
//     Else dcnt+=1.
//   - PRESSED: hcnt+=1. LONG=1 in the cycle after hcnt reaches LONG_PRESS-1.
//     LONG fires once per press. s2=0 -> RELEASE_WAIT, dcnt=0.
//   - RELEASE_WAIT: hcnt keeps counting, and LONG may still fire here.
//     s2=1 -> PRESSED (bounce, no RELEASE, LONG not re-armed).
//     Else if dcnt==DEBOUNCE-1 -> IDLE: RELEASE=1, HELD=0.
//     Else dcnt+=1.
//   Latency: BTN stably high from edge k -> PRESS high for the cycle after
//     edge k+2+DEBOUNCE. Release timing is symmetric.
//   Release and long press in the same cycle: both pulses assert.
//   COUNT wraps 255 -> 0 with no flag.
//   BTN high while RST releases: treated as a fresh press with normal latency.
//   PRESS and RELEASE never assert in the same cycle.
// TESTING
//   1 Reset: RST=0, BTN toggling -> all outputs 0. Release RST -> outputs stay 0
//     while BTN=0.
//   2 Clean press, DEBOUNCE=10: BTN 0->1 at edge k, held -> PRESS 1 cycle after
//     edge k+12, HELD=1, COUNT=1.
//   3 Glitch: BTN high for 5 cycles then low -> no PRESS, COUNT unchanged,
//     FSM back to IDLE.
//   4 Bounce on release: after press, BTN 1-0-1-0 at 3-cycle spacing, then low
//     -> one RELEASE only, 12 cycles after the final fall.
//   5 Long press, LONG_PRESS=100: hold BTN 200 cycles -> one LONG pulse, 100
//     cycles after PRESS. Short 20-cycle hold -> no LONG.
//   6 Wrap and reset: 256 clean presses -> COUNT=0. Assert RST mid-PRESS_WAIT
//     -> no PRESS, COUNT=0.

Source files
------------

// File: rtl/btn_press_counter_if.sv
// Button/event bundle between the board button pin and the LED/control logic.
// The counter owns the event side; whoever drives the raw pin uses master.
interface btn_press_counter_if;
  logic       BTN;
  logic       PRESS;
  logic       RELEASE;
  logic       LONG;
  logic       HELD;
  logic [7:0] COUNT;

  modport master (output BTN, input PRESS, input RELEASE, input LONG, input HELD, input COUNT);
  modport slave  (input BTN, output PRESS, output RELEASE, output LONG, output HELD, output COUNT);
endinterface

// File: rtl/btn_press_counter.sv
// Synchronises and debounces a raw push-button, emits press/release/long-press
// pulses and keeps an 8-bit modulo-256 count of accepted presses.
module btn_press_counter #(
  parameter int unsigned DEBOUNCE   = 10,
  parameter int unsigned LONG_PRESS = 100
) (
  input  logic                CLK,
  input  logic                RST,
  btn_press_counter_if.slave  bus
);

  localparam int unsigned CW      = 32;
  localparam int unsigned DB_LAST = DEBOUNCE - 1;
  localparam int unsigned LP_LAST = LONG_PRESS - 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state, state_n;
  logic            s1, s2;
  logic [CW-1:0]   dcnt, dcnt_n;
  logic [CW-1:0]   hcnt, hcnt_n;
  logic            long_done, long_done_n;
  logic [7:0]      count, count_n;
  logic            held, held_n;
  logic            press_q, press_n;
  logic            release_q, release_n;
  logic            long_q, long_n;

  // Two-flop synchroniser; the FSM only ever looks at s2.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.BTN;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      long_done <= 1'b0;
      count     <= '0;
      held      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state     <= state_n;
      dcnt      <= dcnt_n;
      hcnt      <= hcnt_n;
      long_done <= long_done_n;
      count     <= count_n;
      held      <= held_n;
      press_q   <= press_n;
      release_q <= release_n;
      long_q    <= long_n;
    end
  end

  always_comb begin
    state_n     = state;
    dcnt_n      = dcnt;
    hcnt_n      = hcnt;
    long_done_n = long_done;
    count_n     = count;
    held_n      = held;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;

    // Hold timer runs through release bounces so LONG can still land there.
    if (state == PRESSED || state == RELEASE_WAIT) begin
      if (hcnt != '1) hcnt_n = hcnt + CW'(1);
      if (!long_done && hcnt == CW'(LP_LAST)) begin
        long_n      = 1'b1;
        long_done_n = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (s2) begin
          state_n = PRESS_WAIT;
          dcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_n = IDLE;
        end else if (dcnt == CW'(DB_LAST)) begin
          state_n     = PRESSED;
          press_n     = 1'b1;
          held_n      = 1'b1;
          count_n     = count + 8'd1;
          hcnt_n      = '0;
          long_done_n = 1'b0;
        end else begin
          dcnt_n = dcnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_n = RELEASE_WAIT;
          dcnt_n  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_n = PRESSED;
        end else if (dcnt == CW'(DB_LAST)) begin
          state_n   = IDLE;
          release_n = 1'b1;
          held_n    = 1'b0;
        end else begin
          dcnt_n = dcnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.PRESS   = press_q;
  assign bus.RELEASE = release_q;
  assign bus.LONG    = long_q;
  assign bus.HELD    = held;
  assign bus.COUNT   = count;

endmodule

// File: tb/tb_btn_press_counter.sv
// Directed bench for btn_press_counter with DEBOUNCE=10, LONG_PRESS=100.
`timescale 1ns/1ps
module tb_btn_press_counter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   np, nr, nl;

  btn_press_counter_if bus ();

  btn_press_counter #(.DEBOUNCE(10), .LONG_PRESS(100)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Advance n edges while tallying pulses seen on each event output.
  task automatic run_count(input int n, output int p, output int r, output int l);
    p = 0; r = 0; l = 0;
    repeat (n) begin
      tick(1);
      p += int'(bus.PRESS);
      r += int'(bus.RELEASE);
      l += int'(bus.LONG);
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_press"},   32'(bus.PRESS),   32'd0);
    check({tag, "_release"}, 32'(bus.RELEASE), 32'd0);
    check({tag, "_long"},    32'(bus.LONG),    32'd0);
    check({tag, "_held"},    32'(bus.HELD),    32'd0);
    check({tag, "_count"},   32'(bus.COUNT),   32'd0);
  endtask

  initial begin
    bus.BTN = 1'b0;

    // 1: reset with BTN toggling, then release with BTN low
    for (int i = 0; i < 8; i++) begin
      bus.BTN = ~bus.BTN;
      tick(1);
    end
    all_zero("rst_hold");
    bus.BTN = 1'b0;
    RST = 1'b1;
    run_count(20, np, nr, nl);
    check("rst_idle_pulses", 32'(np + nr + nl), 32'd0);
    all_zero("rst_idle");

    // 2: clean press, PRESS after edge k+12
    bus.BTN = 1'b1;
    run_count(12, np, nr, nl);
    check("press_early", 32'(np), 32'd0);
    tick(1);
    check("press_pulse", 32'(bus.PRESS), 32'd1);
    check("press_held",  32'(bus.HELD),  32'd1);
    check("press_count", 32'(bus.COUNT), 32'd1);
    tick(1);
    check("press_one_cycle", 32'(bus.PRESS), 32'd0);

    // 4: release with bounce 1-0-1-0 at 3-cycle spacing
    bus.BTN = 1'b0; run_count(3, np, nr, nl); check("bnc_r0", 32'(nr), 32'd0);
    bus.BTN = 1'b1; run_count(3, np, nr, nl); check("bnc_r1", 32'(nr + np), 32'd0);
    bus.BTN = 1'b0; run_count(3, np, nr, nl); check("bnc_r2", 32'(nr), 32'd0);
    bus.BTN = 1'b1; run_count(3, np, nr, nl); check("bnc_r3", 32'(nr + np), 32'd0);
    bus.BTN = 1'b0;
    run_count(12, np, nr, nl);
    check("bnc_rel_early", 32'(nr), 32'd0);
    check("bnc_held_early", 32'(bus.HELD), 32'd1);
    tick(1);
    check("bnc_release", 32'(bus.RELEASE), 32'd1);
    check("bnc_held_low", 32'(bus.HELD), 32'd0);
    run_count(30, np, nr, nl);
    check("bnc_single_rel", 32'(nr + np + nl), 32'd0);

    // 3: glitch of 5 cycles
    bus.BTN = 1'b1;
    run_count(5, np, nr, nl);
    bus.BTN = 1'b0;
    run_count(30, nl, nr, np);
    check("glitch_no_press", 32'(np + nl), 32'd0);
    check("glitch_count", 32'(bus.COUNT), 32'd1);
    check("glitch_held", 32'(bus.HELD), 32'd0);
    // back in IDLE: a clean press still has the normal latency
    bus.BTN = 1'b1;
    run_count(12, np, nr, nl);
    check("glitch_idle_early", 32'(np), 32'd0);
    tick(1);
    check("glitch_idle_press", 32'(bus.PRESS), 32'd1);

    // 5: long press, LONG after edge P+100
    run_count(99, np, nr, nl);
    check("long_early", 32'(nl), 32'd0);
    tick(1);
    check("long_pulse", 32'(bus.LONG), 32'd1);
    run_count(88, np, nr, nl);
    check("long_once", 32'(nl), 32'd0);
    bus.BTN = 1'b0;
    run_count(13, np, nr, nl);
    check("long_rel", 32'(nr), 32'd1);
    check("long_rel_nolong", 32'(nl), 32'd0);
    check("long_count", 32'(bus.COUNT), 32'd2);
    // short 20-cycle hold
    bus.BTN = 1'b1;
    run_count(13, np, nr, nl);
    check("short_press", 32'(np), 32'd1);
    run_count(20, np, nr, nl);
    bus.BTN = 1'b0;
    run_count(100, np, nr, nl);
    check("short_nolong", 32'(nl), 32'd0);
    check("short_rel", 32'(nr), 32'd1);
    check("short_count", 32'(bus.COUNT), 32'd3);

    // 6: wrap 255 -> 0
    for (int i = 3; i < 256; i++) begin
      bus.BTN = 1'b1; tick(14);
      bus.BTN = 1'b0; tick(14);
      if (i == 254) check("wrap_255", 32'(bus.COUNT), 32'd255);
    end
    check("wrap_0", 32'(bus.COUNT), 32'd0);
    bus.BTN = 1'b1; tick(14);
    bus.BTN = 1'b0; tick(14);
    check("wrap_1", 32'(bus.COUNT), 32'd1);

    // reset mid-PRESS_WAIT, asynchronous assertion
    bus.BTN = 1'b1;
    tick(6);
    RST = 1'b0;
    #2;
    all_zero("rst_async");
    bus.BTN = 1'b0;
    tick(3);
    RST = 1'b1;
    run_count(30, np, nr, nl);
    check("rst_mid_nopulse", 32'(np + nr + nl), 32'd0);
    check("rst_mid_count", 32'(bus.COUNT), 32'd0);

    // BTN high as reset releases: fresh press with normal latency
    RST = 1'b0;
    bus.BTN = 1'b1;
    tick(2);
    RST = 1'b1;
    run_count(12, np, nr, nl);
    check("rst_btnhi_early", 32'(np), 32'd0);
    tick(1);
    check("rst_btnhi_press", 32'(bus.PRESS), 32'd1);
    check("rst_btnhi_count", 32'(bus.COUNT), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
